// File: rtl/apuf_eval_sequencer.sv
// Evaluation sequencer for an interposed APUF: holds the challenge, fires the
// top then bottom trigger REPS times and majority-votes the response bits.
module apuf_eval_sequencer #(
    parameter int unsigned N           = 64,
    parameter int unsigned REPS        = 15,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned REARM_CYC   = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] chal_in,
    output logic         busy,
    output logic         done,
    output logic         resp_bit,
    output logic [7:0]   ones_cnt,
    output logic         timeout_err,
    output logic [N-1:0] chal_out,
    output logic         tig_t,
    output logic         tig_b,
    input  logic         rdy_t,
    input  logic         rdy_b,
    input  logic         puf_resp
);

    localparam int unsigned MAX_SR  = (SETTLE_CYC > REARM_CYC) ? SETTLE_CYC : REARM_CYC;
    localparam int unsigned CNT_MAX = (MAX_SR > TIMEOUT_CYC) ? MAX_SR : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    // The abort cycle (FINISH) itself is the last counted cycle, so the wait
    // state gives up one count early and done lands TIMEOUT_CYC after the trigger.
    localparam int unsigned TO_LAST = (TIMEOUT_CYC > 1) ? TIMEOUT_CYC - 2 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_FIRE_T,
        S_WAIT_T,
        S_FIRE_B,
        S_WAIT_B,
        S_REARM,
        S_FINISH
    } state_e;

    state_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]     eval_q, eval_d;
    logic [7:0]     ones_q, ones_d;
    logic           terr_q, terr_d;
    logic           resp_q, resp_d;
    logic [N-1:0]   chal_q, chal_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           tig_t_q, tig_t_d;
    logic           tig_b_q, tig_b_d;
    logic           expire_c;
    logic [8:0]     twice_c;

    assign expire_c = (cnt_q >= CNT_W'(TO_LAST));
    assign twice_c  = {ones_d, 1'b0};

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            eval_q  <= '0;
            ones_q  <= '0;
            terr_q  <= 1'b0;
            resp_q  <= 1'b0;
            chal_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tig_t_q <= 1'b0;
            tig_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            eval_q  <= eval_d;
            ones_q  <= ones_d;
            terr_q  <= terr_d;
            resp_q  <= resp_d;
            chal_q  <= chal_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tig_t_q <= tig_t_d;
            tig_b_q <= tig_b_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register cleanly
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eval_d  = eval_q;
        ones_d  = ones_q;
        terr_d  = terr_q;
        resp_d  = resp_q;
        chal_d  = chal_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    chal_d  = chal_in;
                    ones_d  = '0;
                    eval_d  = '0;
                    terr_d  = 1'b0;
                    resp_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIRE_T;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIRE_T: begin
                cnt_d   = '0;
                state_d = S_WAIT_T;
            end
            S_WAIT_T: begin
                if (rdy_t) begin
                    state_d = S_FIRE_B;
                end else if (expire_c) begin
                    terr_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIRE_B: begin
                cnt_d   = '0;
                state_d = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (rdy_b) begin
                    ones_d = (ones_q == 8'hFF) ? ones_q : ones_q + 8'(puf_resp);
                    eval_d = eval_q + 8'd1;
                    cnt_d  = '0;
                    state_d = (eval_d == 8'(REPS)) ? S_FINISH : S_REARM;
                end else if (expire_c) begin
                    terr_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REARM: begin
                if (cnt_q == CNT_W'(REARM_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIRE_T;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // FINISH lasts one cycle, so this fires exactly on entry
        if (state_d == S_FINISH) begin
            resp_d = !terr_d && (twice_c > 9'(REPS));
        end

        busy_d  = (state_d != S_IDLE) && (state_d != S_FINISH);
        done_d  = (state_d == S_FINISH);
        tig_t_d = (state_d == S_FIRE_T);
        tig_b_d = (state_d == S_FIRE_B);
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign resp_bit    = resp_q;
    assign ones_cnt    = ones_q;
    assign timeout_err = terr_q;
    assign chal_out    = chal_q;
    assign tig_t       = tig_t_q;
    assign tig_b       = tig_b_q;

endmodule

// File: tb/tb_apuf_eval_sequencer.sv
// Bench for apuf_eval_sequencer: three instances (REPS 15/4/2) each driven by a
// behavioural PUF model; campaign results are checked through a scoreboard.
module tb_apuf_eval_sequencer;

    localparam int TO = 1024;

    typedef struct {
        int         g;
        logic [7:0] ones;
        logic       resp;
        logic       terr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] chal_in;
    logic        start       [3];
    logic        busy        [3];
    logic        done        [3];
    logic        resp_bit    [3];
    logic [7:0]  ones_cnt    [3];
    logic        timeout_err [3];
    logic [63:0] chal_out    [3];
    logic        tig_t       [3];
    logic        tig_b       [3];
    logic        rdy_t       [3];
    logic        rdy_b       [3];
    logic        puf_resp    [3];

    logic [15:0] pat      [3];
    int          dly_t    [3];
    int          dly_b    [3];
    int          stall_at [3];
    logic [63:0] exp_chal [3];
    int          tt_n     [3];
    int          tb_n     [3];
    int          dn_n     [3];
    int          ovl_n    [3];
    int          cbad_n   [3];
    int          tb_last  [3];

    int   cyc;
    int   checks;
    int   errors;
    exp_t sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gen_inst
        localparam int unsigned R_G = (g == 0) ? 15 : ((g == 1) ? 4 : 2);
        logic rdy_t_l, rdy_b_l, resp_l, arm_t, arm_b;
        int   wt, wb, ev;
        int   tt_l, tb_l, dn_l, ovl_l, cbad_l, last_l;

        apuf_eval_sequencer #(
            .N(64), .REPS(R_G), .SETTLE_CYC(4), .REARM_CYC(8), .TIMEOUT_CYC(TO)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[g]),
            .chal_in    (chal_in),
            .busy       (busy[g]),
            .done       (done[g]),
            .resp_bit   (resp_bit[g]),
            .ones_cnt   (ones_cnt[g]),
            .timeout_err(timeout_err[g]),
            .chal_out   (chal_out[g]),
            .tig_t      (tig_t[g]),
            .tig_b      (tig_b[g]),
            .rdy_t      (rdy_t_l),
            .rdy_b      (rdy_b_l),
            .puf_resp   (resp_l)
        );

        assign rdy_t[g]    = rdy_t_l;
        assign rdy_b[g]    = rdy_b_l;
        assign puf_resp[g] = resp_l;
        assign tt_n[g]     = tt_l;
        assign tb_n[g]     = tb_l;
        assign dn_n[g]     = dn_l;
        assign ovl_n[g]    = ovl_l;
        assign cbad_n[g]   = cbad_l;
        assign tb_last[g]  = last_l;

        // PUF model: ready levels rise a programmable delay after each trigger
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdy_t_l <= 1'b0; rdy_b_l <= 1'b0; resp_l <= 1'b0;
                arm_t <= 1'b0; arm_b <= 1'b0; wt <= 0; wb <= 0; ev <= 0;
            end else begin
                if (start[g] && !busy[g]) ev <= 0;
                if (tig_t[g]) begin
                    rdy_b_l <= 1'b0;
                    if (dly_t[g] == 0) rdy_t_l <= 1'b1;
                    else begin arm_t <= 1'b1; wt <= dly_t[g] - 1; end
                end else if (arm_t) begin
                    if (wt == 0) begin rdy_t_l <= 1'b1; arm_t <= 1'b0; end
                    else wt <= wt - 1;
                end
                if (tig_b[g]) begin
                    rdy_t_l <= 1'b0;
                    ev      <= ev + 1;
                    resp_l  <= pat[g][ev];
                    if (ev != stall_at[g]) begin
                        if (dly_b[g] == 0) rdy_b_l <= 1'b1;
                        else begin arm_b <= 1'b1; wb <= dly_b[g] - 1; end
                    end
                end else if (arm_b) begin
                    if (wb == 0) begin rdy_b_l <= 1'b1; arm_b <= 1'b0; end
                    else wb <= wb - 1;
                end
            end
        end

        initial begin
            tt_l = 0; tb_l = 0; dn_l = 0; ovl_l = 0; cbad_l = 0; last_l = 0;
        end

        // Pulse counters and invariants, sampled away from the active edge
        always @(negedge clk) begin
            if (tig_t[g]) tt_l <= tt_l + 1;
            if (tig_b[g]) begin tb_l <= tb_l + 1; last_l <= cyc; end
            if (done[g]) dn_l <= dn_l + 1;
            if (tig_t[g] && tig_b[g]) ovl_l <= ovl_l + 1;
            if (busy[g] && chal_out[g] !== exp_chal[g]) cbad_l <= cbad_l + 1;
        end
    end

    task automatic launch(input int g, input logic [63:0] chal, input logic [15:0] p,
                          input int dt, input int db, input int stall, input int reps,
                          input bit push, output int c_start);
        exp_t        e;
        logic [15:0] m;
        m      = (stall < 0) ? ((16'h1 << reps) - 16'h1) : ((16'h1 << stall) - 16'h1);
        e.g    = g;
        e.ones = 8'($countones(p & m));
        e.terr = (stall >= 0);
        e.resp = !e.terr && ((2 * int'(e.ones)) > reps);
        @(negedge clk);
        pat[g] = p; dly_t[g] = dt; dly_b[g] = db; stall_at[g] = stall;
        chal_in = chal; exp_chal[g] = chal; start[g] = 1'b1;
        c_start = cyc;
        if (push) sb.push_back(e);
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget, output bit ok, output int c_done);
        ok = 1'b0;
        c_done = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done[g]) begin ok = 1'b1; c_done = cyc; end
        end
    endtask

    task automatic test_reset();
        int tt0 [3];
        int tb0 [3];
        int dn0 [3];
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({busy[g], done[g], tig_t[g], tig_b[g], resp_bit[g], timeout_err[g],
                 ones_cnt[g], chal_out[g]} !== 78'h0) begin
                errors++; $display("FAIL reset_outputs[%0d]: got ones=%0d chal=%h busy=%b, want all zero",
                                   g, ones_cnt[g], chal_out[g], busy[g]);
            end
            tt0[g] = tt_n[g]; tb0[g] = tb_n[g]; dn0[g] = dn_n[g];
        end
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ((tt_n[g] - tt0[g]) + (tb_n[g] - tb0[g]) + (dn_n[g] - dn0[g]) !== 0) begin
                errors++; $display("FAIL idle_activity[%0d]: got %0d trigger/done pulses, want 0", g,
                                   (tt_n[g] - tt0[g]) + (tb_n[g] - tb0[g]) + (dn_n[g] - dn0[g]));
            end
            checks++;
            if ({busy[g], ones_cnt[g], chal_out[g]} !== 73'h0) begin
                errors++; $display("FAIL idle_outputs[%0d]: got busy=%b chal=%h, want 0", g, busy[g], chal_out[g]);
            end
        end
    endtask

    task automatic test_basic_majority();
        int   cs, cd, tt0, tb0, dn0;
        bit   ok;
        exp_t e;
        tt0 = tt_n[0]; tb0 = tb_n[0]; dn0 = dn_n[0];
        launch(0, 64'hDEADBEEF_01234567, 16'b0110110101101011, 2, 3, -1, 15, 1'b1, cs);
        // Requests while busy must not restart or re-latch anything
        repeat (30) @(negedge clk);
        chal_in = 64'h1111_2222_3333_4444; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (10) @(negedge clk);
        chal_in = 64'h5555_6666_7777_8888; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 2000, ok, cd);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done: got no done within budget, want done"); end
        else begin
            e = sb.pop_front();
            checks++;
            if (ones_cnt[0] !== e.ones) begin errors++; $display("FAIL basic_ones: got %0d want %0d", ones_cnt[0], e.ones); end
            checks++;
            if (resp_bit[0] !== e.resp) begin errors++; $display("FAIL basic_resp: got %b want %b", resp_bit[0], e.resp); end
            checks++;
            if (timeout_err[0] !== e.terr) begin errors++; $display("FAIL basic_terr: got %b want %b", timeout_err[0], e.terr); end
            checks++;
            if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy[0]); end
            checks++;
            if (chal_out[0] !== 64'hDEADBEEF_01234567) begin
                errors++; $display("FAIL basic_chal_out: got %h want deadbeef01234567", chal_out[0]);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (tt_n[0] - tt0 !== 15) begin errors++; $display("FAIL basic_tig_t_pulses: got %0d want 15", tt_n[0] - tt0); end
        checks++;
        if (tb_n[0] - tb0 !== 15) begin errors++; $display("FAIL basic_tig_b_pulses: got %0d want 15", tb_n[0] - tb0); end
        checks++;
        if (dn_n[0] - dn0 !== 1) begin errors++; $display("FAIL basic_campaigns: got %0d want 1", dn_n[0] - dn0); end
        checks++;
        if (cbad_n[0] !== 0) begin errors++; $display("FAIL basic_chal_held: got %0d changed cycles want 0", cbad_n[0]); end
        checks++;
        if (ovl_n[0] !== 0) begin errors++; $display("FAIL basic_trigger_overlap: got %0d want 0", ovl_n[0]); end
    endtask

    task automatic test_even_tie();
        int   cs, cd;
        bit   ok;
        exp_t e;
        launch(1, 64'h0123_4567_89AB_CDEF, 16'b0101, 1, 0, -1, 4, 1'b1, cs);
        wait_done(1, 500, ok, cd);
        checks++;
        if (!ok) begin errors++; $display("FAIL tie_done: got no done within budget, want done"); end
        else begin
            e = sb.pop_front();
            checks++;
            if (ones_cnt[1] !== e.ones) begin errors++; $display("FAIL tie_ones: got %0d want %0d", ones_cnt[1], e.ones); end
            checks++;
            if (resp_bit[1] !== e.resp) begin errors++; $display("FAIL tie_resp: got %b want %b", resp_bit[1], e.resp); end
            @(negedge clk);
            checks++;
            if (done[1] !== 1'b0) begin errors++; $display("FAIL tie_done_width: got done=%b one cycle later, want 0", done[1]); end
        end
    endtask

    task automatic test_timing();
        int   cs, cd;
        bit   ok;
        exp_t e;
        launch(2, 64'hA5A5_5A5A_F0F0_0F0F, 16'b11, 0, 0, -1, 2, 1'b1, cs);
        wait_done(2, 200, ok, cd);
        checks++;
        if (!ok) begin errors++; $display("FAIL timing_done: got no done within budget, want done"); end
        else begin
            e = sb.pop_front();
            checks++;
            if (cd - cs !== 21) begin errors++; $display("FAIL timing_latency: got %0d cycles want 21", cd - cs); end
            checks++;
            if ({ones_cnt[2], resp_bit[2], timeout_err[2]} !== {e.ones, e.resp, e.terr}) begin
                errors++; $display("FAIL timing_result: got ones=%0d resp=%b terr=%b want ones=%0d resp=%b terr=%b",
                                   ones_cnt[2], resp_bit[2], timeout_err[2], e.ones, e.resp, e.terr);
            end
        end
    endtask

    task automatic test_timeout();
        int   cs, cd;
        bit   ok;
        exp_t e;
        launch(0, 64'hCAFE_F00D_0000_0001, 16'hFFFF, 0, 0, 2, 15, 1'b1, cs);
        wait_done(0, 3000, ok, cd);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_done: got no done within budget, want done"); end
        else begin
            e = sb.pop_front();
            checks++;
            if (cd - tb_last[0] !== TO) begin
                errors++; $display("FAIL timeout_latency: got %0d cycles after tig_b want %0d", cd - tb_last[0], TO);
            end
            checks++;
            if (timeout_err[0] !== e.terr) begin errors++; $display("FAIL timeout_flag: got %b want %b", timeout_err[0], e.terr); end
            checks++;
            if (ones_cnt[0] !== e.ones) begin errors++; $display("FAIL timeout_partial: got %0d want %0d", ones_cnt[0], e.ones); end
            checks++;
            if (resp_bit[0] !== e.resp) begin errors++; $display("FAIL timeout_resp: got %b want %b", resp_bit[0], e.resp); end
        end
    endtask

    task automatic test_reset_mid();
        int   cs, cd, dn0;
        bit   ok, seen;
        exp_t e;
        launch(0, 64'h0F0F_0F0F_1234_5678, 16'h7FFF, 200, 0, -1, 15, 1'b0, cs);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (tig_t[0]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL midreset_fire: got no tig_t within budget, want pulse"); end
        repeat (3) @(negedge clk);
        dn0 = dn_n[0];
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy[0], done[0], tig_t[0], tig_b[0], ones_cnt[0], chal_out[0]} !== 76'h0) begin
            errors++; $display("FAIL midreset_clear: got busy=%b chal=%h, want all zero", busy[0], chal_out[0]);
        end
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (dn_n[0] !== dn0) begin errors++; $display("FAIL midreset_no_done: got %0d done pulses want 0", dn_n[0] - dn0); end
        launch(0, 64'h8765_4321_0000_FFFF, 16'h7FFF, 0, 0, -1, 15, 1'b1, cs);
        wait_done(0, 1000, ok, cd);
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset_restart: got no done within budget, want done"); end
        else begin
            e = sb.pop_front();
            checks++;
            if ({ones_cnt[0], resp_bit[0], timeout_err[0]} !== {e.ones, e.resp, e.terr}) begin
                errors++; $display("FAIL midreset_result: got ones=%0d resp=%b terr=%b want ones=%0d resp=%b terr=%b",
                                   ones_cnt[0], resp_bit[0], timeout_err[0], e.ones, e.resp, e.terr);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        chal_in = '0;
        for (int g = 0; g < 3; g++) begin
            start[g] = 1'b0; pat[g] = '0; dly_t[g] = 0; dly_b[g] = 0;
            stall_at[g] = -1; exp_chal[g] = '0;
        end
        test_reset();
        test_basic_majority();
        test_even_tie();
        test_timing();
        test_timeout();
        test_reset_mid();
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
